clk_ratio_ctrl: RTL and testbench

APB-programmable clock-ratio controller for the FPGA clock subsystem. It generates a clock-enable pulse train that divides the single `pad_clk` domain by a programmable ratio, so no derived clocks are needed. Ratio changes are applied without glitches: a four-phase idle handshake with the system runs first, then the enable is gated and a settle interval elapses before the new ratio takes effect. It sits beside the clock generator on the peripheral APB and drives the CPU/peripheral clock-enable.

---
 rtl/clk_ratio_ctrl_pkg.sv | 22 ++
 rtl/clk_ratio_ctrl_div.sv | 32 +++
 rtl/clk_ratio_ctrl.sv | 150 +++++++++++++++
 tb/tb_clk_ratio_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_ratio_ctrl_pkg.sv
// Shared types and register map for the clock-ratio controller.
package clk_ctrl_pkg;

  localparam int unsigned RATIO_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_GATE,
    ST_SETTLE,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] CTRL_OFS   = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_TMO       = 1;
  localparam int unsigned STAT_ERR       = 2;
  localparam int unsigned STAT_RATIO_LSB = 4;

endpackage

// File: rtl/clk_ratio_ctrl_div.sv
// Clock-enable divider: one clk_en pulse every ratio+1 cycles.
module clk_en_div
  import clk_ctrl_pkg::*;
(
  input  logic               pad_clk,
  input  logic               clkrst,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               hold,
  input  logic               clr,
  output logic               clk_en
);

  logic [RATIO_W-1:0] cnt;

  // Free-running counter; wraps at ratio, restarts from 0 when held or cleared.
  // Wrapping on >= keeps the period bounded if the ratio ever shrinks mid-count.
  always_ff @(posedge pad_clk) begin
    if (clkrst || hold || clr) begin
      cnt <= '0;
    end else if (cnt >= ratio) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pulse on count zero, forced low while held.
  always_comb begin
    clk_en = ~hold & (cnt == '0);
  end

endmodule

// File: rtl/clk_ratio_ctrl.sv
// APB-programmable clock-ratio controller with idle handshake and glitch-free switch.
module clk_ratio_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT   = 1024
) (
  input  logic               pad_clk,
  input  logic               clkrst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [3:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               sys_idle_req,
  input  logic               sys_idle_ack,
  output logic               clk_en,
  output logic [RATIO_W-1:0] ratio_cur,
  output logic               busy
);

  localparam logic [15:0] TMO_LAST    = 16'(ACK_TIMEOUT - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t             state;
  logic [RATIO_W-1:0] ratio_tgt;
  logic [15:0]        tmo_cnt;
  logic [7:0]         settle_cnt;
  logic               sts_tmo;
  logic               sts_err;

  logic wr_en;
  logic ctrl_wr;
  logic stat_wr;
  logic start_sw;
  logic div_hold;
  logic div_clr;
  logic unused_pwdata;

  always_comb begin
    wr_en    = psel & penable & pwrite;
    ctrl_wr  = wr_en && (paddr == CTRL_OFS);
    stat_wr  = wr_en && (paddr == STATUS_OFS);
    start_sw = ctrl_wr && (state == ST_IDLE) && (pwdata[RATIO_W-1:0] != ratio_cur);
    div_hold = (state == ST_GATE) || (state == ST_SETTLE);
    div_clr  = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
  end

  assign pready        = 1'b1;
  assign unused_pwdata = ^pwdata[31:RATIO_W];

  // Register file, switch FSM, timeout/settle counters; sticky sets are coded
  // after their W1C clears so a same-cycle set wins.
  always_ff @(posedge pad_clk) begin
    if (clkrst) begin
      state        <= ST_IDLE;
      ratio_tgt    <= '0;
      ratio_cur    <= '0;
      tmo_cnt      <= '0;
      settle_cnt   <= '0;
      sts_tmo      <= 1'b0;
      sts_err      <= 1'b0;
      sys_idle_req <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (stat_wr && pwdata[STAT_TMO]) sts_tmo <= 1'b0;
      if (stat_wr && pwdata[STAT_ERR]) sts_err <= 1'b0;

      if (ctrl_wr) begin
        if (state == ST_IDLE) ratio_tgt <= pwdata[RATIO_W-1:0];
        else                  sts_err   <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_sw) begin
            state        <= ST_WAIT_ACK;
            tmo_cnt      <= '0;
            sys_idle_req <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (sys_idle_ack) begin
            state <= ST_GATE;
          end else if (tmo_cnt == TMO_LAST) begin
            state        <= ST_RELEASE;
            sts_tmo      <= 1'b1;
            sys_idle_req <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_GATE: begin
          ratio_cur  <= ratio_tgt;
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state        <= ST_RELEASE;
            sys_idle_req <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!sys_idle_ack) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          sys_idle_req <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read mux, zero unless a read is selected.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        CTRL_OFS: prdata[RATIO_W-1:0] = ratio_tgt;
        STATUS_OFS: begin
          prdata[STAT_BUSY]                     = busy;
          prdata[STAT_TMO]                      = sts_tmo;
          prdata[STAT_ERR]                      = sts_err;
          prdata[STAT_RATIO_LSB +: RATIO_W]     = ratio_cur;
        end
        default: prdata = '0;
      endcase
    end
  end

  clk_en_div u_div (
    .pad_clk (pad_clk),
    .clkrst  (clkrst),
    .ratio   (ratio_cur),
    .hold    (div_hold),
    .clr     (div_clr),
    .clk_en  (clk_en)
  );

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// Self-checking bench for clk_ratio_ctrl (SETTLE_CYCLES=8, ACK_TIMEOUT=16).
module tb_clk_ratio_ctrl;

  logic        pad_clk = 1'b0;
  logic        clkrst  = 1'b1;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [3:0]  paddr   = '0;
  logic [31:0] pwdata  = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        sys_idle_req;
  logic        sys_idle_ack = 1'b0;
  logic        clk_en;
  logic [2:0]  ratio_cur;
  logic        busy;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  logic [31:0] en_q[$];
  logic [31:0] rd_q[$];

  always #5 pad_clk = ~pad_clk;

  clk_ratio_ctrl #(.SETTLE_CYCLES(8), .ACK_TIMEOUT(16)) dut (
    .pad_clk      (pad_clk),
    .clkrst       (clkrst),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .sys_idle_req (sys_idle_req),
    .sys_idle_ack (sys_idle_ack),
    .clk_en       (clk_en),
    .ratio_cur    (ratio_cur),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; compare clk_en against the scoreboard when an entry is pending.
  task automatic tick();
    @(posedge pad_clk);
    #1;
    if (en_q.size() > 0) check("clk_en", 32'(clk_en), en_q.pop_front());
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Setup cycle, access cycle T, returns in cycle T+1.
  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    #1;
    check(tag, prdata, rd_q.pop_front());
    psel = 1'b0;
  endtask

  task automatic do_reset();
    clkrst = 1'b1;
    tick();
    clkrst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset then idle
    ticks(2);
    clkrst = 1'b0;
    check("rst_req", 32'(sys_idle_req), 32'd0);
    check("rst_en", 32'(clk_en), 32'd1);
    check("rst_ratio", 32'(ratio_cur), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("pready", 32'(pready), 32'd1);
    for (int i = 0; i < 20; i++) en_q.push_back(32'd1);
    ticks(20);
    apb_rd("idle_status", 4'h4, 32'h0);
    apb_rd("idle_ctrl", 4'h0, 32'h0);
    apb_wr(4'h8, 32'h7);
    apb_rd("bad_ofs_rd", 4'h8, 32'h0);
    apb_rd("bad_ofs_ctrl", 4'h0, 32'h0);
    check("bad_ofs_busy", 32'(busy), 32'd0);

    // Switch to 3, ack 5 cycles later
    en_q.delete();
    apb_wr(4'h0, 32'h3);
    check("sw_req_t1", 32'(sys_idle_req), 32'd1);
    check("sw_busy_t1", 32'(busy), 32'd1);
    check("sw_en_wait", 32'(clk_en), 32'd1);
    ticks(4);
    sys_idle_ack = 1'b1;
    for (int i = 0; i < 9; i++) en_q.push_back(32'd0);
    for (int i = 0; i < 3; i++) begin
      en_q.push_back(32'd1); en_q.push_back(32'd0);
      en_q.push_back(32'd0); en_q.push_back(32'd0);
    end
    for (int i = 0; i < 21; i++) begin
      tick();
      if (i == 0) check("sw_ratio_gate", 32'(ratio_cur), 32'd0);
      if (i == 1) check("sw_ratio_new", 32'(ratio_cur), 32'd3);
      if (i == 8) check("sw_req_settle", 32'(sys_idle_req), 32'd1);
      if (i == 9) begin
        check("sw_req_release", 32'(sys_idle_req), 32'd0);
        check("sw_busy_release", 32'(busy), 32'd1);
        sys_idle_ack = 1'b0;
      end
      if (i == 10) check("sw_busy_idle", 32'(busy), 32'd0);
    end
    apb_rd("sw_status", 4'h4, 32'h30);

    // Timeout: ratio 2, no ack
    do_reset();
    en_q.delete();
    for (int i = 0; i < 19; i++) en_q.push_back(32'd1);
    apb_wr(4'h0, 32'h2);
    ticks(15);
    check("tmo_busy_last", 32'(busy), 32'd1);
    check("tmo_req_last", 32'(sys_idle_req), 32'd1);
    tick();
    check("tmo_req_rel", 32'(sys_idle_req), 32'd0);
    check("tmo_busy_rel", 32'(busy), 32'd1);
    tick();
    check("tmo_busy_idle", 32'(busy), 32'd0);
    check("tmo_ratio", 32'(ratio_cur), 32'd0);
    apb_rd("tmo_status", 4'h4, 32'h2);
    apb_wr(4'h4, 32'h2);
    apb_rd("tmo_w1c", 4'h4, 32'h0);

    // Write while busy
    en_q.delete();
    apb_wr(4'h0, 32'h1);
    tick();
    apb_wr(4'h0, 32'h5);
    apb_rd("wb_status", 4'h4, 32'h5);
    apb_rd("wb_ctrl", 4'h0, 32'h1);
    sys_idle_ack = 1'b1;
    ticks(10);
    check("wb_req_rel", 32'(sys_idle_req), 32'd0);
    check("wb_en_rel", 32'(clk_en), 32'd1);
    sys_idle_ack = 1'b0;
    tick();
    check("wb_busy_idle", 32'(busy), 32'd0);
    check("wb_ratio", 32'(ratio_cur), 32'd1);
    apb_rd("wb_status2", 4'h4, 32'h14);
    apb_wr(4'h4, 32'h4);
    apb_rd("wb_w1c", 4'h4, 32'h10);

    // Reset mid-SETTLE
    apb_wr(4'h0, 32'h6);
    sys_idle_ack = 1'b1;
    ticks(3);
    check("rs_en_settle", 32'(clk_en), 32'd0);
    check("rs_busy_settle", 32'(busy), 32'd1);
    check("rs_ratio_settle", 32'(ratio_cur), 32'd6);
    sys_idle_ack = 1'b0;
    do_reset();
    check("rs_req", 32'(sys_idle_req), 32'd0);
    check("rs_ratio", 32'(ratio_cur), 32'd0);
    check("rs_en", 32'(clk_en), 32'd1);
    check("rs_busy", 32'(busy), 32'd0);
    apb_rd("rs_status", 4'h4, 32'h0);

    // Same-ratio write
    apb_wr(4'h0, 32'h0);
    check("same_req", 32'(sys_idle_req), 32'd0);
    check("same_busy", 32'(busy), 32'd0);
    ticks(3);
    check("same_busy_later", 32'(busy), 32'd0);

    // Ack arrives in the final timeout cycle: gate is taken
    apb_wr(4'h0, 32'h4);
    ticks(15);
    sys_idle_ack = 1'b1;
    tick();
    check("race_en_gate", 32'(clk_en), 32'd0);
    check("race_ratio_gate", 32'(ratio_cur), 32'd0);
    check("race_busy", 32'(busy), 32'd1);
    tick();
    check("race_ratio_new", 32'(ratio_cur), 32'd4);
    ticks(8);
    check("race_en_rel", 32'(clk_en), 32'd1);
    check("race_req_rel", 32'(sys_idle_req), 32'd0);
    sys_idle_ack = 1'b0;
    tick();
    apb_rd("race_status", 4'h4, 32'h40);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
